// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo family: geometry derivation and threshold legality.
package fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

  function automatic int unsigned usedw_width(input int unsigned awidth);
    return awidth + 32'd1;
  endfunction

  // Both thresholds must lie in 1..depth.
  function automatic bit thresholds_legal(input int unsigned af,
                                          input int unsigned ae,
                                          input int unsigned depth);
    return (af >= 32'd1) && (af <= depth) && (ae >= 32'd1) && (ae <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DWIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = fifo_depth(AWIDTH);

  // Storage is intentionally left without reset.
  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_ext.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, sticky
// overflow/underflow flags and a selectable show-ahead read port.
module fifo_ext
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH             = 8,
  parameter int unsigned AWIDTH_EXP         = 3,
  parameter string       SHOWAHEAD          = "OFF",
  parameter int unsigned ALMOST_FULL_VALUE  = fifo_depth(AWIDTH_EXP) - 32'd2,
  parameter int unsigned ALMOST_EMPTY_VALUE = 2
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [DWIDTH-1:0]     data_i,
  input  logic                  wrreq_i,
  input  logic                  rdreq_i,
  output logic [DWIDTH-1:0]     q_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [AWIDTH_EXP:0]   usedw_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam int unsigned DEPTH   = fifo_depth(AWIDTH_EXP);
  localparam int unsigned UW      = usedw_width(AWIDTH_EXP);
  localparam bit          SHOW_ON = (SHOWAHEAD == "ON");
  localparam bit          SHOW_OK = SHOW_ON || (SHOWAHEAD == "OFF");

  if (!SHOW_OK) begin : g_bad_showahead
    $fatal(1, "fifo_ext: SHOWAHEAD must be \"ON\" or \"OFF\"");
  end
  if (!thresholds_legal(ALMOST_FULL_VALUE, ALMOST_EMPTY_VALUE, DEPTH)) begin : g_bad_threshold
    $fatal(1, "fifo_ext: almost-full/almost-empty thresholds out of range");
  end

  logic [AWIDTH_EXP-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH_EXP-1:0] rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]         usedw_q, usedw_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DWIDTH-1:0]     mem_rdata;

  // Acceptance uses the registered flags from before the edge.
  assign wr_acc = wrreq_i & ~full_q;
  assign rd_acc = rdreq_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH_EXP'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AWIDTH_EXP'(1);
    usedw_d  = usedw_q + UW'(wr_acc) - UW'(rd_acc);
    if (wrreq_i && full_q)  ovf_d = 1'b1;
    if (rdreq_i && empty_q) udf_d = 1'b1;
    // Flags follow the next-state count so they move on the same edge.
    empty_d  = (usedw_d == '0);
    full_d   = (usedw_d == UW'(DEPTH));
    afull_d  = (usedw_d >= UW'(ALMOST_FULL_VALUE));
    aempty_d = (usedw_d <  UW'(ALMOST_EMPTY_VALUE));
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH_EXP)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc & ~srst_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  if (SHOW_ON) begin : g_showahead
    assign q_o = mem_rdata;
  end else begin : g_normal
    logic [DWIDTH-1:0] q_q;
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        q_q <= '0;
      end else if (rd_acc) begin
        q_q <= mem_rdata;
      end
    end
    assign q_o = q_q;
  end

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign usedw_o        = usedw_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign ovf_o          = ovf_q;
  assign udf_o          = udf_q;

endmodule

// File: tb/tb_fifo_ext.sv
// Bench for fifo_ext: normal and show-ahead instances share stimulus and are
// compared each cycle against a queue model, plus table rows with fixed values.
module tb_fifo_ext;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] din;
  logic          wrreq;
  logic          rdreq;

  logic [DW-1:0] q_off, q_on;
  logic          empty_off, full_off, af_off, ae_off, ovf_off, udf_off;
  logic          empty_on, full_on, af_on, ae_on, ovf_on, udf_on;
  logic [AW:0]   usedw_off, usedw_on;

  always #5 clk = ~clk;

  fifo_ext #(
    .DWIDTH(DW), .AWIDTH_EXP(AW), .SHOWAHEAD("OFF"),
    .ALMOST_FULL_VALUE(AF), .ALMOST_EMPTY_VALUE(AE)
  ) u_off (
    .clk_i(clk), .srst_i(srst), .data_i(din), .wrreq_i(wrreq), .rdreq_i(rdreq),
    .q_o(q_off), .empty_o(empty_off), .full_o(full_off), .usedw_o(usedw_off),
    .almost_full_o(af_off), .almost_empty_o(ae_off), .ovf_o(ovf_off), .udf_o(udf_off)
  );

  fifo_ext #(
    .DWIDTH(DW), .AWIDTH_EXP(AW), .SHOWAHEAD("ON"),
    .ALMOST_FULL_VALUE(AF), .ALMOST_EMPTY_VALUE(AE)
  ) u_on (
    .clk_i(clk), .srst_i(srst), .data_i(din), .wrreq_i(wrreq), .rdreq_i(rdreq),
    .q_o(q_on), .empty_o(empty_on), .full_o(full_on), .usedw_o(usedw_on),
    .almost_full_o(af_on), .almost_empty_o(ae_on), .ovf_o(ovf_on), .udf_o(udf_on)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: data queue acts as the scoreboard.
  logic [DW-1:0] sb[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_qoff;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] d;
    int            usedw;
    logic          ovf;
    logic          udf;
    logic [DW-1:0] q;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_status();
    int n = sb.size();
    return {4'(n), n == 0, n == DEPTH, n >= AF, n < AE, m_ovf, m_udf};
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    logic was_full, was_empty;
    if (r) begin
      sb.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_qoff = '0;
    end else begin
      was_full  = (sb.size() == DEPTH);
      was_empty = (sb.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      if (rd && !was_empty) m_qoff = sb.pop_front();
      if (w && !was_full) sb.push_back(d);
    end
  endtask

  task automatic check_model();
    check("status_off", 32'({usedw_off, empty_off, full_off, af_off, ae_off, ovf_off, udf_off}),
          32'(exp_status()));
    check("status_on", 32'({usedw_on, empty_on, full_on, af_on, ae_on, ovf_on, udf_on}),
          32'(exp_status()));
    check("q_off", 32'(q_off), 32'(m_qoff));
    if (sb.size() != 0) check("q_on", 32'(q_on), 32'(sb[0]));
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, sample 1ns later.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    @(negedge clk);
    srst = r; wrreq = w; rdreq = rd; din = d;
    @(posedge clk);
    model_edge(r, w, rd, d);
    #1;
    check_model();
  endtask

  function automatic vec_t mk(input logic w, input logic rd, input logic [DW-1:0] d,
                              input int u, input logic o, input logic un, input logic [DW-1:0] q);
    vec_t v;
    v.wr = w; v.rd = rd; v.d = d; v.usedw = u; v.ovf = o; v.udf = un; v.q = q;
    return v;
  endfunction

  int lvl;
  logic rw, rr;

  initial begin
    srst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; din = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_qoff = '0;

    // Fill 1..8, overflow write, drain 8, underflow read.
    for (int i = 1; i <= DEPTH; i++) vecs.push_back(mk(1'b1, 1'b0, 8'(i), i, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h99, 8, 1'b1, 1'b0, 8'h00));
    for (int i = 1; i <= DEPTH; i++) vecs.push_back(mk(1'b0, 1'b1, 8'h00, DEPTH - i, 1'b1, 1'b0, 8'(i)));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h08));

    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("reset_usedw", 32'(usedw_off), 32'd0);
    check("reset_q", 32'(q_off), 32'd0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].d);
      check($sformatf("vec%0d_usedw", i), 32'(usedw_off), 32'(vecs[i].usedw));
      check($sformatf("vec%0d_ovf", i), 32'(ovf_off), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_udf", i), 32'(udf_off), 32'(vecs[i].udf));
      check($sformatf("vec%0d_q", i), 32'(q_off), 32'(vecs[i].q));
    end

    // Simultaneous rd+wr at usedw=4.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
    check("rw_mid_usedw", 32'(usedw_off), 32'd4);

    // rd+wr while full: write dropped.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    check("rw_full_usedw", 32'(usedw_off), 32'd7);
    check("rw_full_ovf", 32'(ovf_off), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("dropped_absent", 32'(q_off == 8'hEE), 32'd0);
    end

    // rd+wr while empty: read ignored.
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    check("rw_empty_usedw", 32'(usedw_off), 32'd1);
    check("rw_empty_udf", 32'(udf_off), 32'd1);

    // Show-ahead latency.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    check("sa_empty", 32'(empty_on), 32'd0);
    check("sa_first", 32'(q_on), 32'hA5);
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("sa_next", 32'(q_on), 32'h3C);
    check("off_latency", 32'(q_off), 32'hA5);

    // Random traffic, usedw kept in 2..6, long enough for several pointer wraps.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 120; i++) begin
      lvl = sb.size();
      rw = ($urandom_range(3) != 0);
      rr = ($urandom_range(3) != 0);
      if (lvl >= 6 && rw && !rr) rw = 1'b0;
      if (lvl <= 2 && rr && !rw) rr = 1'b0;
      step(1'b0, rw, rr, 8'($urandom));
    end

    // Reset mid-stream at usedw=5 with ovf set; concurrent write discarded.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    check("pre_rst_usedw", 32'(usedw_off), 32'd5);
    check("pre_rst_ovf", 32'(ovf_off), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'hC3);
    check("rst_usedw", 32'(usedw_off), 32'd0);
    check("rst_flags", 32'({empty_off, full_off, af_off, ae_off, ovf_off, udf_off}), 32'b100100);
    check("rst_q", 32'(q_off), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_write_dropped", 32'(empty_on), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
